fifo_uart_tx: RTL and testbench

Downstream consumer for the 8-bit synchronous FIFO (FIFO_sync, depth 16). It pops one byte whenever the FIFO is non-empty and transmits it as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the FIFO read port and the chip-level serial TX pin, and reports frame-level status.

---
 rtl/fifo_uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 32 +++
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each bit.
module uart_baud_gen
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_bit_tick = (r_count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a synchronous FIFO and sends them as async serial frames
// (start, 8 data LSB first, optional parity, 1 or 2 stop bits).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_bit_idx;
  logic              r_parity;
  logic              r_stop_idx;
  logic              r_tx;
  logic              r_frame_done;

  logic              w_clear;
  logic              w_tick;
  logic [CNT_W-1:0]  w_count;
  logic              w_start_ok;
  logic              w_last_stop;

  // Counter is held at zero until the frame starts, so START always begins at count 0.
  assign w_clear     = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);
  assign w_start_ok  = tx_en && !fifo_empty;
  assign w_last_stop = (r_state == STOP) && (r_stop_idx == STOP_LAST);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_clear    (w_clear),
    .o_count    (w_count),
    .o_bit_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= 3'd0;
      r_parity     <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      // Raised one cycle early so the pulse lands on the last stop-bit cycle.
      r_frame_done <= w_last_stop && (w_count == PRE_LAST);
      case (r_state)
        IDLE: begin
          if (w_start_ok) r_state <= FETCH;
        end
        FETCH: begin
          r_state <= LOAD;
        end
        LOAD: begin
          r_shift  <= fifo_dout;
          r_parity <= parity_bit(fifo_dout, PARITY_ODD != 0);
          r_tx     <= 1'b0;
          r_state  <= START;
        end
        START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= 3'd0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_state    <= STOP;
              end
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop_idx == STOP_LAST) begin
              r_state <= w_start_ok ? FETCH : IDLE;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = (r_state == FETCH);
  assign busy       = (r_state != IDLE);
  assign tx         = r_tx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: four transmitter configurations, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] tx_en;
  logic [3:0] empty_w, rd_w, tx_w, busy_w, done_w;
  logic [7:0] dout [4];
  logic [7:0] q_mem [4][16];
  int         q_wr [4];
  int         q_rd [4];
  int         rd_cnt [4];
  int         bad_pop [4];
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .reset(reset), .tx_en(tx_en[0]), .fifo_dout(dout[0]), .fifo_empty(empty_w[0]),
    .fifo_rd_en(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .reset(reset), .tx_en(tx_en[1]), .fifo_dout(dout[1]), .fifo_empty(empty_w[1]),
    .fifo_rd_en(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
    .clk(clk), .reset(reset), .tx_en(tx_en[2]), .fifo_dout(dout[2]), .fifo_empty(empty_w[2]),
    .fifo_rd_en(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));
  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
    .clk(clk), .reset(reset), .tx_en(tx_en[3]), .fifo_dout(dout[3]), .fifo_empty(empty_w[3]),
    .fifo_rd_en(rd_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

  always_comb begin
    empty_w = 4'hF;
    for (int k = 0; k < 4; k++) empty_w[k] = (q_wr[k] == q_rd[k]);
  end

  // FIFO read port: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rd_w[k] === 1'b1) begin
        dout[k]   <= q_mem[k][q_rd[k] % 16];
        q_rd[k]   <= q_rd[k] + 1;
        rd_cnt[k] <= rd_cnt[k] + 1;
        if (empty_w[k]) bad_pop[k] <= bad_pop[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    q_mem[k][q_wr[k] % 16] = b;
    q_wr[k] = q_wr[k] + 1;
  endtask

  // Waits for the start bit, then samples every bit mid-period over nbits*4 cycles.
  task automatic capture(input int k, input int nbits, output logic [15:0] bits,
                         output int donecyc, output int ndone, output int gap,
                         output int lead, output bit busy_drop);
    int last_rd;
    bits = '0; donecyc = 0; ndone = 0; gap = 0; lead = 0; busy_drop = 1'b0; last_rd = -100;
    while (tx_w[k] !== 1'b0 && gap < 1000) begin
      @(negedge clk);
      gap++;
      if (rd_w[k] === 1'b1) last_rd = gap;
      if (busy_w[k] !== 1'b1) busy_drop = 1'b1;
    end
    lead = gap - last_rd;
    check("frame_start", 32'(tx_w[k]), 32'd0);
    for (int c = 1; c <= nbits * 4; c++) begin
      if (c > 1) @(negedge clk);
      if ((c - 1) % 4 == 2) bits[(c - 1) / 4] = tx_w[k];
      if (done_w[k] === 1'b1) begin
        donecyc = c;
        ndone++;
      end
      if (busy_w[k] !== 1'b1) busy_drop = 1'b1;
    end
  endtask

  initial begin
    logic [15:0] bits;
    logic [15:0] exp_bits;
    int dc, nd, gap, lead, base;
    bit bd;

    reset = 1'b1;
    tx_en = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_w), 32'hF);
    check("rst_busy", 32'(busy_w), 32'h0);
    check("rst_rd_en", 32'(rd_w), 32'h0);
    check("rst_done", 32'(done_w), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Test 1: reset mid-DATA
    push(0, 8'h5A);
    tx_en[0] = 1'b1;
    for (int g = 0; g < 50 && tx_w[0] !== 1'b0; g++) @(negedge clk);
    check("t1_start", 32'(tx_w[0]), 32'd0);
    repeat (10) @(negedge clk);
    check("t1_busy_mid", 32'(busy_w[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("t1_rst_tx", 32'(tx_w[0]), 32'd1);
    check("t1_rst_busy", 32'(busy_w[0]), 32'd0);
    check("t1_rst_rd_en", 32'(rd_w[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = rd_cnt[0];
    repeat (100) @(negedge clk);
    check("t1_no_pop", 32'(rd_cnt[0] - base), 32'd0);
    check("t1_idle_tx", 32'(tx_w[0]), 32'd1);

    // Test 2: single byte 0xA5
    base = rd_cnt[0];
    push(0, 8'hA5);
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t2_bits", 32'(bits), 32'h34A);
    check("t2_fetch_to_low", 32'(lead), 32'd2);
    check("t2_done_cycle", 32'(dc), 32'd40);
    check("t2_done_count", 32'(nd), 32'd1);
    @(negedge clk);
    check("t2_pops", 32'(rd_cnt[0] - base), 32'd1);
    check("t2_idle", 32'(busy_w[0]), 32'd0);

    // Test 3: back-to-back 0x00, 0xFF
    repeat (3) @(negedge clk);
    base = rd_cnt[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t3_bits0", 32'(bits), 32'h200);
    check("t3_busy0", 32'(bd), 32'd0);
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t3_gap_high", 32'(gap - 1), 32'd2);
    check("t3_bits1", 32'(bits), 32'h3FE);
    check("t3_busy1", 32'(bd), 32'd0);
    @(negedge clk);
    check("t3_pops", 32'(rd_cnt[0] - base), 32'd2);
    check("t3_idle", 32'(busy_w[0]), 32'd0);

    // Test 4: parity even and odd on 0x07
    tx_en[1] = 1'b1;
    push(1, 8'h07);
    capture(1, 11, bits, dc, nd, gap, lead, bd);
    check("t4_even_bits", 32'(bits), 32'h60E);
    check("t4_even_par", 32'(bits[9]), 32'd1);
    check("t4_even_len", 32'(dc), 32'd44);
    @(negedge clk);
    check("t4_even_idle", 32'(busy_w[1]), 32'd0);
    tx_en[2] = 1'b1;
    push(2, 8'h07);
    capture(2, 11, bits, dc, nd, gap, lead, bd);
    check("t4_odd_bits", 32'(bits), 32'h40E);
    check("t4_odd_par", 32'(bits[9]), 32'd0);
    check("t4_odd_len", 32'(dc), 32'd44);
    @(negedge clk);
    check("t4_odd_idle", 32'(busy_w[2]), 32'd0);

    // Test 5: flow control
    base = rd_cnt[0];
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    for (int g = 0; g < 50 && rd_w[0] !== 1'b1; g++) @(negedge clk);
    check("t5_fetch", 32'(rd_w[0]), 32'd1);
    tx_en[0] = 1'b0;
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t5_bits0", 32'(bits), 32'h222);
    repeat (60) @(negedge clk);
    check("t5_held_pops", 32'(rd_cnt[0] - base), 32'd1);
    check("t5_held_idle", 32'(busy_w[0]), 32'd0);
    check("t5_held_tx", 32'(tx_w[0]), 32'd1);
    tx_en[0] = 1'b1;
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t5_bits1", 32'(bits), 32'h244);
    capture(0, 10, bits, dc, nd, gap, lead, bd);
    check("t5_bits2", 32'(bits), 32'h266);
    @(negedge clk);
    check("t5_pops", 32'(rd_cnt[0] - base), 32'd3);

    // Test 6: two stop bits, drain 16 bytes
    base = rd_cnt[3];
    for (int i = 0; i < 16; i++) push(3, 8'(i));
    tx_en[3] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      capture(3, 11, bits, dc, nd, gap, lead, bd);
      exp_bits = 16'h0600 | 16'(i << 1);
      check($sformatf("t6_bits%0d", i), 32'(bits), 32'(exp_bits));
      check($sformatf("t6_done%0d", i), 32'(dc), 32'd44);
      if (i > 0) check($sformatf("t6_gap%0d", i), 32'(gap - 1), 32'd2);
    end
    @(negedge clk);
    check("t6_pops", 32'(rd_cnt[3] - base), 32'd16);
    check("t6_empty", 32'(empty_w[3]), 32'd1);
    check("t6_idle", 32'(busy_w[3]), 32'd0);
    check("empty_pops", 32'(bad_pop[0] + bad_pop[1] + bad_pop[2] + bad_pop[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
